// File: rtl/greedy_snake_pkg.sv
// Shared definitions for the greedy-snake pipeline: grid geometry, map layout,
// food-placement FSM states and the LFSR feedback taps.
package greedy_snake_pkg;

  localparam int GRID_DIM = 16;
  localparam int POS_W    = 8;
  localparam int MAP_W    = GRID_DIM * GRID_DIM;
  localparam int LFSR_W   = 8;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PROBE = 1'b1
  } food_state_e;

  // Cell index inside the occupancy bitmap: {y, x}
  function automatic logic [POS_W-1:0] cell_index(input logic [3:0] y, input logic [3:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/greedy_snake_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR with synchronous reset to a seed.
// Steps every cycle out of reset; a zero state (only reachable by a bad seed) reloads the seed.
module greedy_snake_lfsr8
  import greedy_snake_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hB8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] tap_bits;
  logic              feedback;

  for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_tap
    assign tap_bits[gi] = lfsr_reg[gi] & LFSR_TAPS[gi];
  end

  assign feedback = ^tap_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (lfsr_reg == '0) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[LFSR_W-2:0], feedback};
    end
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/greedy_snake_food_gen.sv
// Food placement: snapshots the occupancy map on request and linearly probes from a
// pseudo-random cell until a free one is found or every cell has been tried.
module greedy_snake_food_gen
  import greedy_snake_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [MAP_W-1:0] i_map,
  output logic             busy,
  output logic             food_valid,
  output logic [POS_W-1:0] food_pos,
  output logic             board_full
);

  food_state_e       state_reg;
  logic [MAP_W-1:0]  map_reg;
  logic [POS_W-1:0]  ptr_reg;
  logic [POS_W-1:0]  cnt_reg;
  logic [POS_W-1:0]  food_pos_reg;
  logic              food_valid_reg;
  logic              board_full_reg;
  logic [LFSR_W-1:0] lfsr;

  greedy_snake_lfsr8 #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .lfsr(lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      map_reg        <= '0;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      food_pos_reg   <= '0;
      food_valid_reg <= 1'b0;
      board_full_reg <= 1'b0;
    end else begin
      food_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            map_reg        <= i_map;
            // Start one below the LFSR value so cell 0 is reachable despite a non-zero LFSR
            ptr_reg        <= lfsr - 8'd1;
            cnt_reg        <= '0;
            board_full_reg <= 1'b0;
            state_reg      <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (!map_reg[ptr_reg]) begin
            food_pos_reg   <= ptr_reg;
            food_valid_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else if (cnt_reg == 8'hFF) begin
            board_full_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else begin
            ptr_reg <= ptr_reg + 8'd1;
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_reg == ST_PROBE);
  assign food_valid = food_valid_reg;
  assign food_pos   = food_pos_reg;
  assign board_full = board_full_reg;

endmodule

// File: tb/tb_greedy_snake_food_gen.sv
// Directed and randomized checks of the food generator against a search model
// driven by a precomputed LFSR sequence indexed by cycles since reset.
module tb_greedy_snake_food_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [255:0] i_map = '0;
  logic         busy;
  logic         food_valid;
  logic [7:0]   food_pos;
  logic         board_full;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  logic [7:0]   seq [255];
  logic [7:0]   exp_pos  = 8'h00;
  logic         exp_full = 1'b0;
  logic [255:0] wrap_map;

  greedy_snake_food_gen #(.LFSR_SEED(8'hB8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .i_map     (i_map),
    .busy      (busy),
    .food_valid(food_valid),
    .food_pos  (food_pos),
    .board_full(board_full)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since reset released = index into the LFSR sequence
  always @(posedge clk) begin
    if (rst) n_cyc <= 0;
    else     n_cyc <= n_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, food_valid, 0);
    chk({tag, "_pos"}, food_pos, 0);
    chk({tag, "_full"}, board_full, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    exp_pos  = 8'h00;
    exp_full = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", food_valid, 0);
      chk("idle_full", board_full, exp_full);
      chk("idle_pos", food_pos, exp_pos);
    end
  endtask

  // Issues one request; returns at the cycle the result (or full flag) appears.
  task automatic do_req(input logic [255:0] map, input int disturb_at, input int abort_at,
                        output int obs_k, output logic [7:0] obs_pos);
    logic [7:0] start;
    logic [7:0] p;
    int         k;
    bit         found;
    start = seq[n_cyc % 255] - 8'd1;
    found = 0;
    k     = 256;
    p     = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (!found && !map[8'(start + 8'(i))]) begin
        found = 1;
        k     = i + 1;
        p     = start + 8'(i);
      end
    end
    i_map = map;
    req   = 1'b1;
    @(posedge clk); #1;
    req   = 1'b0;
    obs_k = 0;
    while (busy === 1'b1 && obs_k < 300) begin
      obs_k++;
      chk("probe_valid", food_valid, 0);
      chk("probe_full", board_full, 0);
      req = 1'b0;
      if (obs_k == disturb_at) begin
        i_map = ~map;
        req   = 1'b1;
      end
      if (obs_k == abort_at) begin
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          chk_outputs_zero("abort");
        end
        rst      = 1'b0;
        exp_pos  = 8'h00;
        exp_full = 1'b0;
        obs_pos  = food_pos;
        return;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("busy_cycles", obs_k, k);
    chk("result_valid", food_valid, found);
    chk("result_full", board_full, !found);
    if (found) exp_pos = p;
    exp_full = !found;
    chk("result_pos", food_pos, exp_pos);
    obs_pos = food_pos;
  endtask

  initial begin
    int           k;
    logic [7:0]   pos;
    logic [7:0]   s;
    logic [255:0] m;
    int           mode;
    int           gap;

    s = 8'hB8;
    for (int i = 0; i < 255; i++) begin
      seq[i] = s;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    wrap_map = '1;
    wrap_map[2] = 1'b0;

    // Reset held 3 cycles with req high
    rst = 1'b1;
    req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_outputs_zero("rst_hold");
    end
    rst = 1'b0;
    req = 1'b0;

    // First-cycle request on an empty map
    do_req('0, -1, -1, k, pos);
    chk("first_pos", pos, 8'hB7);
    chk("first_busy", k, 1);
    idle(2);

    // Wrap-around search
    do_reset();
    do_req(wrap_map, -1, -1, k, pos);
    chk("wrap_pos", pos, 8'h02);
    chk("wrap_busy", k, 76);
    idle(2);

    // Full board, then recovery with an empty map
    do_req('1, -1, -1, k, pos);
    chk("full_busy", k, 256);
    chk("full_flag", board_full, 1);
    chk("full_pos_held", pos, 8'h02);
    idle(3);
    do_req('0, -1, -1, k, pos);
    chk("recover_full", board_full, 0);
    idle(1);

    // Snapshot isolation plus a dropped request while busy
    do_reset();
    do_req(wrap_map, 5, -1, k, pos);
    chk("snap_pos", pos, 8'h02);
    chk("snap_busy", k, 76);
    idle(5);

    // Reset mid-search, then a clean first-cycle request
    do_reset();
    do_req(wrap_map, -1, 10, k, pos);
    chk("abort_pos", pos, 8'h00);
    do_req('0, -1, -1, k, pos);
    chk("after_abort_pos", pos, 8'hB7);
    chk("after_abort_busy", k, 1);
    idle(1);

    // Randomized maps; gap 0 exercises a request in the result cycle
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 4);
      for (int w = 0; w < 8; w++) begin
        case (mode)
          0:       m[w*32 +: 32] = $urandom & $urandom;
          1:       m[w*32 +: 32] = $urandom | $urandom | $urandom;
          default: m[w*32 +: 32] = 32'hFFFF_FFFF;
        endcase
      end
      if (mode == 2 || mode == 3) m[$urandom_range(0, 255)] = 1'b0;
      do_req(m, (mode == 3) ? 2 : -1, -1, k, pos);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
